alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/alu_multicycle.sv | 165 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, controller state encoding and flag bit positions
// for the multi-cycle ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_INC   = 5'h02;
  localparam logic [4:0] OP_DEC   = 5'h03;
  localparam logic [4:0] OP_AND   = 5'h04;
  localparam logic [4:0] OP_OR    = 5'h05;
  localparam logic [4:0] OP_XOR   = 5'h06;
  localparam logic [4:0] OP_NOT   = 5'h07;
  localparam logic [4:0] OP_SLL   = 5'h08;
  localparam logic [4:0] OP_SRL   = 5'h09;
  localparam logic [4:0] OP_SRA   = 5'h0A;
  localparam logic [4:0] OP_EQ    = 5'h0B;
  localparam logic [4:0] OP_SLT   = 5'h0C;
  localparam logic [4:0] OP_SLTU  = 5'h0D;
  localparam logic [4:0] OP_NAND  = 5'h0E;
  localparam logic [4:0] OP_NOR   = 5'h0F;
  localparam logic [4:0] OP_MUL   = 5'h10;
  localparam logic [4:0] OP_MULHU = 5'h11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_O    = 2;
  localparam int FLAG_N    = 3;
  localparam int FLAG_P    = 4;
  localparam int NUM_FLAGS = 5;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle.
// The operands are captured on start; done is raised during the cycle in
// which the last partial product is being added, and product then already
// includes it, so the caller can register product on that edge.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_p0;
  logic [2*WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0]   mplier_p0;
  logic [CNT_W-1:0]   cnt_p0;
  logic               run_p0;
  logic [2*WIDTH-1:0] pp;

  assign pp      = mplier_p0[0] ? mcand_p0 : '0;
  assign product = acc_p0 + pp;
  assign done    = run_p0 && (cnt_p0 == CNT_W'(WIDTH - 1));

  // Load operands on start, then accumulate one shifted multiplicand per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_p0  <= '0;
      acc_p0    <= '0;
      mplier_p0 <= '0;
      cnt_p0    <= '0;
      run_p0    <= 1'b0;
    end else if (start) begin
      mcand_p0  <= {{WIDTH{1'b0}}, a};
      acc_p0    <= '0;
      mplier_p0 <= b;
      cnt_p0    <= '0;
      run_p0    <= 1'b1;
    end else if (run_p0) begin
      acc_p0    <= product;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      cnt_p0    <= cnt_p0 + CNT_W'(1);
      if (done) run_p0 <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops with latency 1 and an
// iterative multiplier for MUL/MULHU, behind a valid/ready handshake with a
// registered, back-pressure-holding result stage.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [4:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             negative_flag,
  output logic             parity_flag,
  output logic             illegal_op,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  state_t                 state, state_next;
  logic                   accept, is_mul, mul_done, mulhu_p0;
  logic [2*WIDTH-1:0]     product;
  logic [WIDTH-1:0]       b_eff, alu_res, mul_res, result_p1;
  logic [WIDTH:0]         sum, diff;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [SH_W-1:0]        shamt;
  logic                   alu_c, alu_o, mul_c;
  logic [NUM_FLAGS-1:0]   flags_p1;
  logic                   vld_p1, illegal_p1;

  function automatic logic [NUM_FLAGS-1:0] make_flags(input logic [WIDTH-1:0] r,
                                                      input logic c, input logic o);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_O] = o;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_P] = ^r;
    return f;
  endfunction

  assign in_ready = !rst && (state == ST_IDLE) && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (operation == OP_MUL) || (operation == OP_MULHU);
  assign busy     = (state == ST_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (input_a),
    .b       (input_b),
    .done    (mul_done),
    .product (product)
  );

  // INC/DEC reuse the add/subtract path with a constant one operand
  assign b_eff = ((operation == OP_INC) || (operation == OP_DEC)) ? WIDTH'(1) : input_b;
  assign sum   = {1'b0, input_a} + {1'b0, b_eff};
  assign diff  = {1'b0, input_a} - {1'b0, b_eff};
  assign a_s   = input_a;
  assign b_s   = input_b;
  assign shamt = input_b[SH_W-1:0];

  // Single-cycle result and carry/overflow; reserved and multiply opcodes yield zero here
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (operation)
      OP_ADD, OP_INC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = (input_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_o   = (input_a[WIDTH-1] != b_eff[WIDTH-1]) && (diff[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_AND:  alu_res = input_a & input_b;
      OP_OR:   alu_res = input_a | input_b;
      OP_XOR:  alu_res = input_a ^ input_b;
      OP_NOT:  alu_res = ~input_a;
      OP_SLL:  alu_res = input_a << shamt;
      OP_SRL:  alu_res = input_a >> shamt;
      OP_SRA:  alu_res = a_s >>> shamt;
      OP_EQ:   alu_res = WIDTH'(input_a == input_b);
      OP_SLT:  alu_res = WIDTH'(a_s < b_s);
      OP_SLTU: alu_res = WIDTH'(input_a < input_b);
      OP_NAND: alu_res = ~(input_a & input_b);
      OP_NOR:  alu_res = ~(input_a | input_b);
      default: alu_res = '0;
    endcase
  end

  // Carry flags a non-zero discarded half of the double-width product
  assign mul_res = mulhu_p0 ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
  assign mul_c   = mulhu_p0 ? (|product[WIDTH-1:0]) : (|product[2*WIDTH-1:WIDTH]);

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state: only an accepted multiply leaves IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_next = ST_MUL;
      ST_MUL:  if (mul_done)         state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Remember which half of the product the pending multiply returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   mulhu_p0 <= 1'b0;
    else if (accept && is_mul) mulhu_p0 <= (operation == OP_MULHU);
  end

  // Result stage: load a new result, otherwise hold until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      result_p1  <= '0;
      flags_p1   <= '0;
      illegal_p1 <= 1'b0;
    end else if (accept && !is_mul) begin
      vld_p1     <= 1'b1;
      result_p1  <= alu_res;
      flags_p1   <= make_flags(alu_res, alu_c, alu_o);
      illegal_p1 <= (operation > OP_MULHU);
    end else if (mul_done && (state == ST_MUL)) begin
      vld_p1     <= 1'b1;
      result_p1  <= mul_res;
      flags_p1   <= make_flags(mul_res, mul_c, 1'b0);
      illegal_p1 <= 1'b0;
    end else if (out_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign out_valid     = vld_p1;
  assign output_result = result_p1;
  assign zero_flag     = flags_p1[FLAG_Z];
  assign carry_flag    = flags_p1[FLAG_C];
  assign overflow_flag = flags_p1[FLAG_O];
  assign negative_flag = flags_p1[FLAG_N];
  assign parity_flag   = flags_p1[FLAG_P];
  assign illegal_op    = illegal_p1;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: a 16-bit instance driven with directed
// and random requests under random back-pressure, plus a 32-bit instance for
// wide shift, reserved-opcode and multiply cases.
module tb_alu_multicycle;

  localparam int W = 16;

  typedef struct packed {
    logic [31:0] res;
    logic        z, c, o, n, p, ill;
    logic [7:0]  lat;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic         zf, cf, of, nf, pf, ill;
  logic [4:0]   operation;
  logic [W-1:0] a, b, result;

  logic         in_valid_w, in_ready_w, out_valid_w, busy_w;
  logic         zf_w, cf_w, of_w, nf_w, pf_w, ill_w;
  logic [4:0]   operation_w;
  logic [31:0]  a_w, b_w, result_w;
  logic         out_ready_w = 1'b1;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(a), .input_b(b), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .output_result(result),
    .zero_flag(zf), .carry_flag(cf), .overflow_flag(of), .negative_flag(nf),
    .parity_flag(pf), .illegal_op(ill), .busy(busy)
  );

  alu_multicycle #(.WIDTH(32)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .input_a(a_w), .input_b(b_w), .operation(operation_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .output_result(result_w),
    .zero_flag(zf_w), .carry_flag(cf_w), .overflow_flag(of_w), .negative_flag(nf_w),
    .parity_flag(pf_w), .illegal_op(ill_w), .busy(busy_w)
  );

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  bit   seen = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit out_of_range(input longint v, input int w);
    longint maxs;
    maxs = longint'((64'd1 << (w - 1)) - 64'd1);
    return (v > maxs) || (v < -maxs - 1);
  endfunction

  // Reference: plain arithmetic on wide integers, masked to w bits
  function automatic exp_t model(input int w, input logic [4:0] op,
                                 input logic [31:0] ai, input logic [31:0] bi);
    exp_t e;
    longint unsigned mask, x, y, r, p;
    longint sx, sy;
    int sh;
    bit c, o, il;
    mask = (64'd1 << w) - 64'd1;
    x  = {32'd0, ai} & mask;
    y  = {32'd0, bi} & mask;
    sh = int'(y % longint'(w));
    sx = x[w-1] ? longint'(x) - longint'(mask) - 1 : longint'(x);
    sy = y[w-1] ? longint'(y) - longint'(mask) - 1 : longint'(y);
    p  = x * y;
    r = 0; c = 0; o = 0; il = 0;
    case (op)
      5'd0:  begin r = (x + y) & mask; c = ((x + y) >> w) != 0; o = out_of_range(sx + sy, w); end
      5'd1:  begin r = (x - y) & mask; c = x < y;               o = out_of_range(sx - sy, w); end
      5'd2:  begin r = (x + 1) & mask; c = x == mask;           o = out_of_range(sx + 1, w);  end
      5'd3:  begin r = (x - 1) & mask; c = x == 0;              o = out_of_range(sx - 1, w);  end
      5'd4:  r = x & y;
      5'd5:  r = x | y;
      5'd6:  r = x ^ y;
      5'd7:  r = ~x & mask;
      5'd8:  r = (x << sh) & mask;
      5'd9:  r = x >> sh;
      5'd10: r = longint'(sx >>> sh) & mask;
      5'd11: r = (x == y) ? 1 : 0;
      5'd12: r = (sx < sy) ? 1 : 0;
      5'd13: r = (x < y) ? 1 : 0;
      5'd14: r = ~(x & y) & mask;
      5'd15: r = ~(x | y) & mask;
      5'd16: begin r = p & mask; c = (p >> w) != 0;   end
      5'd17: begin r = p >> w;   c = (p & mask) != 0; end
      default: il = 1;
    endcase
    e.res = r[31:0];
    e.z   = (r == 0);
    e.c   = c;
    e.o   = o;
    e.n   = r[w-1];
    e.p   = ^r;
    e.ill = il;
    e.lat = (op == 5'd16 || op == 5'd17) ? 8'(w + 1) : 8'd1;
    e.cyc = 32'd0;
    return e;
  endfunction

  // Monitor: compare every presented output against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got out_valid=1 result=%h, expected no output", result);
      end else begin
        e = q[0];
        if (!seen) begin
          check("latency", 64'(cyc), 64'(e.cyc + 32'(e.lat) - 32'd1));
          seen = 1'b1;
        end
        check("result_flags", 64'({ill, zf, cf, of, nf, pf, result}),
              64'({e.ill, e.z, e.c, e.o, e.n, e.p, e.res[W-1:0]}));
        if (out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Random back-pressure, enabled only during the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom % 4) != 0;
    end
  end

  // Issue one request (called just after a rising edge); push its expectation on accept
  task automatic send(input logic [4:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      output int waits);
    exp_t e;
    operation = op; a = xa; b = xb; in_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 300) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", waits);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(W, op, 32'(xa), 32'(xb));
    e.cyc = 32'(cyc);
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", q.size());
      q.delete();
      seen = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // One request on the 32-bit instance, waiting for and checking its result
  task automatic op32(input logic [4:0] op, input logic [31:0] xa, input logic [31:0] xb);
    exp_t e;
    int n, acc;
    operation_w = op; a_w = xa; b_w = xb; in_valid_w = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready_w && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    acc = cyc;
    e = model(32, op, xa, xb);
    n = 0;
    @(negedge clk);
    while (!out_valid_w && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("w32_latency", 64'(cyc - acc), 64'(e.lat - 8'd1));
    check("w32_result_flags", 64'({ill_w, zf_w, cf_w, of_w, nf_w, pf_w, result_w}),
          64'({e.ill, e.z, e.c, e.o, e.n, e.p, e.res}));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0:       return '0;
      1:       return '1;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int w;
    logic [4:0] rop;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; operation = '0; a = '0; b = '0;
    in_valid_w = 1'b0; operation_w = '0; a_w = '0; b_w = '0;

    #3;
    check("reset_outputs", 64'({out_valid, busy, ill, zf, cf, of, nf, pf, result}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_outputs_w32", 64'({out_valid_w, busy_w, ill_w, zf_w, cf_w, of_w, nf_w, pf_w, result_w}), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed single-cycle and multiply cases
    send(5'h00, 16'h7FFF, 16'h0001, w);
    send(5'h10, 16'h0100, 16'h0100, w);
    @(negedge clk);
    check("busy_during_mul", 64'({busy, in_ready}), 64'b10);
    send(5'h11, 16'h0100, 16'h0100, w);
    send(5'h02, 16'hFFFF, 16'h0000, w);
    send(5'h03, 16'h0000, 16'h0000, w);
    send(5'h03, 16'h8000, 16'h0000, w);
    send(5'h01, 16'h8000, 16'h0001, w);
    send(5'h0A, 16'h8000, 16'h000F, w);
    send(5'h08, 16'h0001, 16'h00FF, w);
    send(5'h0C, 16'hFFFF, 16'h0001, w);
    send(5'h0D, 16'hFFFF, 16'h0001, w);
    send(5'h1F, 16'h1234, 16'h5678, w);
    send(5'h10, 16'hFFFF, 16'hFFFF, w);
    drain();

    // Back-pressure: SUB result held for five stalled cycles
    out_ready = 1'b0;
    send(5'h01, 16'h0003, 16'h0009, w);
    operation = 5'h00; a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'({in_ready, out_valid}), 64'b01);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(5'h00, 16'h0001, 16'h0002, w);
    check("accept_when_ready_rises", 64'(w), 64'd0);
    drain();

    // Reset in the middle of a multiply
    send(5'h10, 16'h1234, 16'h5678, w);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midmul_reset_outputs", 64'({out_valid, busy, ill, zf, cf, of, nf, pf, result}), 64'd0);
    q.delete();
    seen = 1'b0;
    @(negedge clk);
    check("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_midmul_reset", 64'(in_ready), 64'd1);
    repeat (30) @(posedge clk);
    #1;
    send(5'h00, 16'h0007, 16'h0005, w);
    drain();

    // Random requests under random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rop = ($urandom % 5 == 0) ? 5'(5'h10 + ($urandom % 2)) : 5'($urandom % 32);
      send(rop, pick(), pick(), w);
      if ($urandom % 6 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    rand_ready = 1'b0;
    #1 out_ready = 1'b1;
    drain();

    // 32-bit instance
    op32(5'h0A, 32'h8000_0000, 32'd31);
    op32(5'h15, 32'h1234_5678, 32'h9ABC_DEF0);
    op32(5'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op32(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op32(5'h00, 32'hFFFF_FFFF, 32'h0000_0001);
    op32(5'h09, 32'h8000_0000, 32'd31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
